mem_bus_arbiter: RTL and testbench

- Shares the single memory-map bus (Memory_Map_Decoder master side: MemRead, MemWrite, address, write data, read data) between two masters.
- Master 0 is the multicycle core (CPU). Master 1 is the UART program loader / debug master (LDR).
- Owner-based FSM with one-cycle turnaround, bounded hold time, and a loader lock for atomic bursts.
- Produces a CPU stall used to gate PCWrite/IRWrite while the CPU waits for the bus.

---
 rtl/mem_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the memory-map decoder bus between the multicycle CPU (master 0)
//   and the UART loader / debug master (master 1). Ownership is decided by
//   an owner FSM: IDLE -> OWN_CPU / OWN_LDR -> (TURN) -> other owner. A
//   one-cycle TURN separates the two owners. While the other master waits,
//   an owner is forced off after MAX_HOLD beats unless the loader holds
//   ldr_lock.
//
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   cpu_*            CPU request side; cpu_stall = cpu_req & ~cpu_gnt
//   ldr_*            loader request side; ldr_lock blocks forced hand-off
//   bus_re/bus_we    MemRead / MemWrite to the decoder (one per beat)
//   bus_addr/wdata   owner's address / write data, CPU's when no beat
//   bus_rdata        decoder read data, valid one cycle after a read beat
module mem_bus_arbiter #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int MAX_HOLD    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_LENGTH-1:0] cpu_addr,
    input  logic [DATA_LENGTH-1:0] cpu_wdata,
    output logic                   cpu_gnt,
    output logic                   cpu_rvalid,
    output logic                   cpu_stall,
    input  logic                   ldr_req,
    input  logic                   ldr_we,
    input  logic                   ldr_lock,
    input  logic [ADDR_LENGTH-1:0] ldr_addr,
    input  logic [DATA_LENGTH-1:0] ldr_wdata,
    output logic                   ldr_gnt,
    output logic                   ldr_rvalid,
    output logic                   bus_re,
    output logic                   bus_we,
    output logic [ADDR_LENGTH-1:0] bus_addr,
    output logic [DATA_LENGTH-1:0] bus_wdata,
    input  logic [DATA_LENGTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_LDR, TURN} state_e;
    typedef enum logic {M_CPU = 1'b0, M_LDR = 1'b1} master_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    master_e    last_owner_q, last_owner_d;
    master_e    pending_next_q, pending_next_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       cpu_rvalid_q, cpu_rvalid_d;
    logic       ldr_rvalid_q, ldr_rvalid_d;

    logic       cpu_beat, ldr_beat;
    logic       own_req, oth_req, locked;
    master_e    own_id, oth_id;

    assign cpu_gnt   = (state_q == OWN_CPU);
    assign ldr_gnt   = (state_q == OWN_LDR);
    assign cpu_beat  = cpu_gnt & cpu_req;
    assign ldr_beat  = ldr_gnt & ldr_req;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Owner-relative view; only meaningful in the OWN states.
    assign own_req = (state_q == OWN_LDR) ? ldr_req : cpu_req;
    assign oth_req = (state_q == OWN_LDR) ? cpu_req : ldr_req;
    assign own_id  = (state_q == OWN_LDR) ? M_LDR : M_CPU;
    assign oth_id  = (state_q == OWN_LDR) ? M_CPU : M_LDR;
    assign locked  = (state_q == OWN_LDR) & ldr_lock;

    // Bus is forced to its reset values while rst is low, since the
    // address/data otherwise follow the CPU inputs combinationally.
    assign bus_re    = rst & ((cpu_beat & ~cpu_we) | (ldr_beat & ~ldr_we));
    assign bus_we    = rst & ((cpu_beat & cpu_we) | (ldr_beat & ldr_we));
    assign bus_addr  = !rst ? '0 : (ldr_beat ? ldr_addr : cpu_addr);
    assign bus_wdata = !rst ? '0 : (ldr_beat ? ldr_wdata : cpu_wdata);

    assign cpu_rvalid = cpu_rvalid_q;
    assign ldr_rvalid = ldr_rvalid_q;

    always_comb begin
        state_d        = state_q;
        last_owner_d   = last_owner_q;
        pending_next_d = pending_next_q;
        hold_cnt_d     = hold_cnt_q;
        cpu_rvalid_d   = cpu_beat & ~cpu_we;
        ldr_rvalid_d   = ldr_beat & ~ldr_we;

        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (cpu_req && ldr_req)
                    state_d = (last_owner_q == M_LDR) ? OWN_CPU : OWN_LDR;
                else if (cpu_req)
                    state_d = OWN_CPU;
                else if (ldr_req)
                    state_d = OWN_LDR;
            end
            OWN_CPU, OWN_LDR: begin
                if (!own_req) begin
                    last_owner_d = own_id;
                    if (oth_req) begin
                        state_d        = TURN;
                        pending_next_d = oth_id;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (oth_req) begin
                    // This beat completes; hand-off happens after it.
                    if (hold_cnt_q == HOLD_LAST && !locked) begin
                        state_d        = TURN;
                        pending_next_d = oth_id;
                        last_owner_d   = own_id;
                    end else if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
            end
            TURN: begin
                // Granted even if the pending master dropped its request;
                // it then leaves through the normal OWN exit.
                hold_cnt_d = '0;
                state_d    = (pending_next_q == M_CPU) ? OWN_CPU : OWN_LDR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            last_owner_q   <= M_LDR;
            pending_next_q <= M_CPU;
            hold_cnt_q     <= '0;
            cpu_rvalid_q   <= 1'b0;
            ldr_rvalid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_owner_q   <= last_owner_d;
            pending_next_q <= pending_next_d;
            hold_cnt_q     <= hold_cnt_d;
            cpu_rvalid_q   <= cpu_rvalid_d;
            ldr_rvalid_q   <= ldr_rvalid_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter (MAX_HOLD=4): a vector table, directed
// multi-cycle sequences, then random traffic against an ownership model.
module tb_mem_bus_arbiter;
    localparam int MH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_req   [2];
    logic        m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        m_lock;
    logic        cpu_gnt, cpu_rvalid, cpu_stall, ldr_gnt, ldr_rvalid;
    logic        bus_re, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_LENGTH(32), .DATA_LENGTH(32), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(m_req[0]), .cpu_we(m_we[0]), .cpu_addr(m_addr[0]),
        .cpu_wdata(m_wdata[0]), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_stall(cpu_stall),
        .ldr_req(m_req[1]), .ldr_we(m_we[1]), .ldr_lock(m_lock),
        .ldr_addr(m_addr[1]), .ldr_wdata(m_wdata[1]), .ldr_gnt(ldr_gnt),
        .ldr_rvalid(ldr_rvalid),
        .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    // Decoder-side memory: synchronous, one-cycle read latency.
    logic [31:0] bmem [256];
    function automatic logic [7:0] idx(input logic [31:0] a);
        return a[9:2] ^ a[23:16];
    endfunction
    initial begin
        for (int i = 0; i < 256; i++) bmem[i] = '0;
        bus_rdata = '0;
    end
    always @(posedge clk) begin
        if (bus_we) bmem[idx(bus_addr)] <= bus_wdata;
        if (bus_re) bus_rdata <= bmem[idx(bus_addr)];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl();
        return {cpu_gnt, ldr_gnt, cpu_stall, bus_re, bus_we, cpu_rvalid, ldr_rvalid};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_req[i] = 0; m_we[i] = 0; m_addr[i] = '0; m_wdata[i] = '0;
        end
        m_lock = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        clear_inputs();
        tick();
        tick();
        rst = 1;
    endtask

    // ---------------- reference model ----------------
    int          r_owner;      // -1: nobody, 0: CPU, 1: loader
    bit          r_turning;    // in the dead cycle between owners
    int          r_next, r_last, r_streak;
    bit          r_rv [2];
    logic [31:0] r_rvdata [2];
    bit          r_beat_prev [2];
    logic [31:0] ref_mem [logic [31:0]];

    task automatic model_reset();
        r_owner = -1; r_turning = 0; r_next = 0; r_last = 1; r_streak = 0;
        for (int i = 0; i < 2; i++) begin
            r_rv[i] = 0; r_beat_prev[i] = 0;
        end
    endtask

    function automatic bit r_gnt(input int i);
        return !r_turning && r_owner == i;
    endfunction

    task automatic model_check();
        bit b[2];
        bit re, we;
        logic [31:0] ea;
        re = 0; we = 0;
        for (int i = 0; i < 2; i++) begin
            b[i] = r_gnt(i) && m_req[i];
            if (b[i] && m_we[i])  we = 1;
            if (b[i] && !m_we[i]) re = 1;
        end
        ea = b[1] ? m_addr[1] : m_addr[0];
        chk("rnd_ctl", ctl(), {r_gnt(0), r_gnt(1), m_req[0] && !r_gnt(0), re, we, r_rv[0], r_rv[1]});
        chk("rnd_addr", bus_addr, ea);
        chk("rnd_wdata", bus_wdata, b[1] ? m_wdata[1] : m_wdata[0]);
        for (int i = 0; i < 2; i++)
            if (r_rv[i]) chk("rnd_rdata", bus_rdata, r_rvdata[i]);
    endtask

    task automatic model_step();
        bit b[2];
        int x, o;
        for (int i = 0; i < 2; i++) b[i] = r_gnt(i) && m_req[i];
        for (int i = 0; i < 2; i++) begin
            r_rv[i] = b[i] && !m_we[i];
            if (r_rv[i]) r_rvdata[i] = ref_mem.exists(m_addr[i]) ? ref_mem[m_addr[i]] : '0;
        end
        for (int i = 0; i < 2; i++)
            if (b[i] && m_we[i]) ref_mem[m_addr[i]] = m_wdata[i];
        if (r_turning) begin
            r_turning = 0; r_owner = r_next; r_streak = 0;
        end else if (r_owner < 0) begin
            r_streak = 0;
            if (m_req[0] && m_req[1]) r_owner = 1 - r_last;
            else if (m_req[0])        r_owner = 0;
            else if (m_req[1])        r_owner = 1;
        end else begin
            x = r_owner; o = 1 - x;
            if (!m_req[x]) begin
                r_last = x; r_owner = -1;
                if (m_req[o]) begin r_turning = 1; r_next = o; end
            end else if (m_req[o]) begin
                if (r_streak == MH - 1 && !(x == 1 && m_lock)) begin
                    r_last = x; r_owner = -1; r_turning = 1; r_next = o;
                end else if (r_streak < MH - 1) begin
                    r_streak++;
                end
            end
        end
        for (int i = 0; i < 2; i++) r_beat_prev[i] = b[i];
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst_n;
        bit          creq, cwe;
        logic [31:0] caddr;
        bit          lreq, lwe;
        logic [31:0] laddr;
        logic [6:0]  exp_ctl;   // cgnt lgnt stall re we crv lrv
        logic [31:0] exp_addr;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit cq, input bit cw, input logic [31:0] ca,
                                input bit lq, input bit lw, input logic [31:0] la,
                                input logic [6:0] ec, input logic [31:0] ea);
        vec_t v;
        v.rst_n = r; v.creq = cq; v.cwe = cw; v.caddr = ca;
        v.lreq = lq; v.lwe = lw; v.laddr = la; v.exp_ctl = ec; v.exp_addr = ea;
        return v;
    endfunction

    initial begin
        vec_t tbl[14];
        logic [1:0] eg;
        int p;

        rst = 0;
        clear_inputs();

        tbl[0]  = mk(0, 0,0,32'h0,        0,0,32'h0,  7'b0000000, 32'h0);
        tbl[1]  = mk(1, 0,0,32'h0,        0,0,32'h0,  7'b0000000, 32'h0);
        tbl[2]  = mk(1, 1,0,32'h0040_0000,0,0,32'h0,  7'b0010000, 32'h0040_0000);
        tbl[3]  = mk(1, 1,0,32'h0040_0000,0,0,32'h0,  7'b1001000, 32'h0040_0000);
        tbl[4]  = mk(1, 0,0,32'h0040_0000,0,0,32'h0,  7'b1000010, 32'h0040_0000);
        tbl[5]  = mk(1, 0,0,32'h0,        0,0,32'h0,  7'b0000000, 32'h0);
        tbl[6]  = mk(0, 0,0,32'h0,        0,0,32'h0,  7'b0000000, 32'h0);
        tbl[7]  = mk(1, 1,0,32'h40,       1,0,32'h80, 7'b0010000, 32'h40);
        tbl[8]  = mk(1, 1,0,32'h40,       1,0,32'h80, 7'b1001000, 32'h40);
        tbl[9]  = mk(1, 0,0,32'h40,       1,0,32'h80, 7'b1000010, 32'h40);
        tbl[10] = mk(1, 0,0,32'h40,       1,0,32'h80, 7'b0000000, 32'h40);
        tbl[11] = mk(1, 0,0,32'h40,       1,0,32'h80, 7'b0101000, 32'h80);
        tbl[12] = mk(1, 0,0,32'h40,       0,0,32'h80, 7'b0100001, 32'h40);
        tbl[13] = mk(1, 0,0,32'h40,       0,0,32'h80, 7'b0000000, 32'h40);

        tick();
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst_n;
            m_req[0] = tbl[i].creq; m_we[0] = tbl[i].cwe; m_addr[0] = tbl[i].caddr;
            m_req[1] = tbl[i].lreq; m_we[1] = tbl[i].lwe; m_addr[1] = tbl[i].laddr;
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), ctl(), tbl[i].exp_ctl);
            chk($sformatf("vec%0d_addr", i), bus_addr, tbl[i].exp_addr);
            tick();
        end

        // Rotation under constant contention: 4 CPU, TURN, 4 LDR, TURN.
        do_reset();
        m_req[0] = 1; m_addr[0] = 32'h40;
        m_req[1] = 1; m_addr[1] = 32'h80;
        for (int c = 0; c < 30; c++) begin
            p = (c - 1) % 10;
            eg = (c == 0) ? 2'b00 : (p < 4) ? 2'b10 : (p == 4 || p == 9) ? 2'b00 : 2'b01;
            @(negedge clk);
            chk($sformatf("rot_c%0d", c), {cpu_gnt, ldr_gnt}, eg);
            tick();
        end

        // Lock: loader keeps the bus for 20 beats, then hands off.
        do_reset();
        m_req[0] = 1; m_addr[0] = 32'h40;
        m_req[1] = 1; m_addr[1] = 32'h80;
        for (int c = 0; c < 30; c++) begin
            m_lock = (c < 25);
            eg = (c == 0 || c == 5 || c == 26) ? 2'b00 :
                 (c >= 6 && c <= 25) ? 2'b01 : 2'b10;
            @(negedge clk);
            chk($sformatf("lock_c%0d", c), {cpu_gnt, ldr_gnt}, eg);
            tick();
        end

        // Loader write then CPU read of the same word.
        do_reset();
        m_req[1] = 1; m_we[1] = 1; m_addr[1] = 32'h1001_0000; m_wdata[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_idle", {ldr_gnt, bus_we}, 2'b00);
        tick();
        @(negedge clk);
        chk("wr_beat", {ldr_gnt, bus_we, bus_re}, 3'b110);
        chk("wr_addr", bus_addr, 32'h1001_0000);
        chk("wr_data", bus_wdata, 32'hDEAD_BEEF);
        tick();
        m_req[1] = 0;
        m_req[0] = 1; m_we[0] = 0; m_addr[0] = 32'h1001_0000;
        @(negedge clk);
        chk("wr_after", {ldr_gnt, bus_we, ldr_rvalid}, 3'b100);
        tick();
        @(negedge clk);
        chk("wr_turn", {cpu_gnt, ldr_gnt, ldr_rvalid}, 3'b000);
        tick();
        @(negedge clk);
        chk("rd_beat", {cpu_gnt, bus_re, bus_we}, 3'b110);
        tick();
        m_req[0] = 0;
        @(negedge clk);
        chk("rd_valid", {cpu_rvalid, ldr_rvalid}, 2'b10);
        chk("rd_data", bus_rdata, 32'hDEAD_BEEF);
        tick();

        // Reset right after a read beat discards the pending rvalid.
        do_reset();
        m_req[0] = 1; m_addr[0] = 32'h40;
        tick();
        @(negedge clk);
        chk("rst_beat", {cpu_gnt, bus_re}, 2'b11);
        tick();
        rst = 0; m_req[0] = 0;
        #1;
        chk("rst_ctl", ctl(), 7'b0);
        chk("rst_addr", bus_addr, 32'h0);
        tick();
        rst = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_idle%0d", c), {cpu_gnt, ldr_gnt, cpu_rvalid}, 3'b000);
            tick();
        end

        // Random traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_req[i] || r_beat_prev[i]) begin
                    m_req[i]   = ($urandom_range(0, 9) < 6);
                    m_we[i]    = 1'($urandom_range(0, 1));
                    m_addr[i]  = 32'h2000_0200 + 32'(4 * $urandom_range(0, 7));
                    m_wdata[i] = $urandom;
                end
            end
            if ($urandom_range(0, 7) == 0) m_lock = ~m_lock;
            @(negedge clk);
            model_check();
            model_step();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
